// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: matches a runtime-programmed 2..PAT_W bit pattern on a
// valid-qualified bit stream, in overlapping or non-overlapping mode, with a saturating count.
module seq_pattern_detector #(
    parameter  int unsigned PAT_W = 8,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             in_valid,
    input  logic             in,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             overlap_q, overlap_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cfg_err_q, cfg_err_d;

    logic [PAT_W-1:0] hist_acc;
    logic [LEN_W-1:0] fill_inc;
    logic [PAT_W-1:0] len_mask;
    logic             cfg_ok;
    logic             hit;

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;
        cnt_d     = cnt_q;

        hist_acc = {hist_q[PAT_W-2:0], in};
        fill_inc = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
        // Only the low len bits take part; a len of PAT_W shifts the ones out entirely.
        len_mask = ~({PAT_W{1'b1}} << len_q);
        hit      = (fill_inc >= len_q) && (((hist_acc ^ pattern_q) & len_mask) == '0);
        cfg_ok   = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(PAT_W));

        if (cfg_load && cfg_ok) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else begin
            cfg_err_d = cfg_load;
            if (in_valid) begin
                hist_d  = hist_acc;
                match_d = hit;
                fill_d  = (hit && !overlap_q) ? '0 : fill_inc;
            end
        end

        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= PAT_W'(2);
            len_q     <= LEN_W'(3);
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised successor to the team's fixed "010" serial sequence detector.
- Detects a runtime-programmable bit pattern of 2..PAT_W bits on a serial input with a valid qualifier.
- Supports overlapping and non-overlapping match modes and keeps a saturating match counter.
- Sits on a serial bit stream between an input deserialiser/sampler and control logic that consumes match pulses.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>= 2).
- CNT_W, 16, width of the match counter.
- LEN_W, $clog2(PAT_W+1), width of the length field (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- cfg_load  input  1  load cfg_pattern, cfg_len and cfg_overlap this cycle.
- cfg_pattern  input  PAT_W  pattern; bit [len-1] matches the oldest received bit, bit [0] the newest.
- cfg_len  input  LEN_W  pattern length; legal range 2..PAT_W.
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
- in_valid  input  1  the input bit is accepted this cycle.
- in  input  1  serial data bit.
- clr_cnt  input  1  clear the match counter.
- match  output  1  one-cycle pulse when the pattern completes.
- match_cnt  output  CNT_W  saturating count of matches.
- cfg_err  output  1  one-cycle pulse when a cfg_load is rejected.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. Every register updates only on the rising edge of clk.
- Reset values:
  - pattern register = 'b010, len = 3, overlap = 1 (this reproduces the predecessor's function).
  - hist = 0, fill = 0.
  - match = 0, match_cnt = 0, cfg_err = 0.
- Reset mid-stream discards all history.
- Accepting a bit: when in_valid = 1 and cfg_load = 0:
  - hist <= {hist[PAT_W-2:0], in}.
  - fill <= min(fill+1, PAT_W).
  - When in_valid = 0, hist and fill hold and the value on in is ignored.
- Match condition, evaluated on the accepted bit: fill_after >= len AND hist_after[len-1:0] == pattern[len-1:0].
- Latency: match is registered. It is 1 in the cycle after the completing bit is accepted, for exactly one cycle. It is 0 in every other cycle, including cycles after an in_valid = 0 cycle.
- Overlap = 1: fill is unchanged by a match, so the suffix of one match can begin the next.
- Overlap = 0: on a match, fill <= 0 in place of the increment. The next match needs len freshly accepted bits.
- Configuration, on cfg_load = 1:
  - If 2 <= cfg_len <= PAT_W: latch pattern, len and overlap. Clear hist and fill. Any in_valid bit in that cycle is dropped. No match is produced that cycle.
  - Otherwise: the configuration is unchanged, cfg_err pulses 1 the next cycle, and in_valid is processed normally.
- cfg_load priority: cfg_load (legal) > in_valid.
- Pattern bits above len-1 are don't-care.
- Counter:
  - match_cnt increments in the same edge that sets match.
  - It saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt sets match_cnt to 0 and wins over a simultaneous increment. The match pulse itself is still produced.
- Fill is always less than or equal to PAT_W.
- Before len valid bits have been accepted, no match is possible, even if the zeroed history equals the pattern.

Test Plan:
1. Reset defaults, in_valid = 1 every cycle, in = 0,1,0,1,0 -> match 1 in the cycle after bits 3 and 5, 0 elsewhere; match_cnt = 2.
2. Load 'b010, len 3, overlap 0; stream 0,1,0,1,0,1,0 -> matches after bits 3 and 7 only; match_cnt = 2. The same stream with overlap 1 gives 3 matches.
3. Load 8'b0000_1101, len 4; present 1,1,0,1 with in_valid low for 2 cycles between each bit and in = 1 during the gaps -> exactly one match, after the 4th valid bit.
4. Load 8'h00, len 8, overlap 1 right after reset; feed 10 zeros -> no match on bits 1..7; matches after bits 8, 9 and 10; match_cnt = 3.
5. cfg_load with cfg_len = 1, then with cfg_len = 9 -> cfg_err pulses each time; config stays 010/3. A following 0,1,0 still matches. Separately: reset asserted after 0,1 then deasserted, then feed 0 -> no match.
6. CNT_W = 4, 20 overlapping matches -> match_cnt holds at 15. clr_cnt on the same cycle as a match -> match pulses and match_cnt = 0.
